// File: rtl/pe_dbuf.sv
// Systolic-array processing element with a double-buffered weight, valid-tagged
// data flow, saturating MAC and weight-stationary / output-stationary dataflows.
module pe_dbuf #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32,
    parameter int SATURATE     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    signed_mode,
    input  logic                    activ_valid_in,
    input  logic [DATA_WIDTH-1:0]   activ_input,
    output logic                    activ_valid_out,
    output logic [DATA_WIDTH-1:0]   activ_output,
    input  logic                    weight_shift_in,
    input  logic [DATA_WIDTH-1:0]   weight_input,
    output logic                    weight_shift_out,
    output logic [DATA_WIDTH-1:0]   weight_output,
    input  logic                    weight_swap,
    input  logic                    top_sum_valid,
    input  logic [RESULT_WIDTH-1:0] top_sum_input,
    output logic                    sum_valid_out,
    output logic [RESULT_WIDTH-1:0] sum_output,
    input  logic                    acc_clear,
    input  logic                    drain,
    output logic                    overflow
);

    localparam int DW = DATA_WIDTH;
    localparam int RW = RESULT_WIDTH;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   shadow_w, shadow_w_nxt;
    logic [DW-1:0]   active_w, active_w_nxt;
    logic [RW-1:0]   acc, acc_nxt;
    logic            activ_valid_nxt, weight_shift_nxt, sum_valid_nxt, overflow_nxt;
    logic [DW-1:0]   activ_output_nxt, weight_output_nxt;
    logic [RW-1:0]   sum_output_nxt;

    logic [RW:0]     ws_mac, os_mac;
    logic            os_pair;

    // Returns {overflow, result}; the sum is formed one bit wider than the result
    // so both signed and unsigned range violations show up in the top bits.
    function automatic logic [RW:0] mac(input logic [RW-1:0] addend,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic          sgn);
        logic [RW-1:0] a_ext, b_ext, prod, res;
        logic [RW:0]   sum;
        logic          ovf;
        a_ext = sgn ? {{(RW-DW){a[DW-1]}}, a} : {{(RW-DW){1'b0}}, a};
        b_ext = sgn ? {{(RW-DW){b[DW-1]}}, b} : {{(RW-DW){1'b0}}, b};
        prod  = a_ext * b_ext;
        sum   = sgn ? ({addend[RW-1], addend} + {prod[RW-1], prod})
                    : ({1'b0, addend} + {1'b0, prod});
        ovf   = sgn ? (sum[RW] ^ sum[RW-1]) : sum[RW];
        res   = sum[RW-1:0];
        if (ovf && SATURATE != 0) begin
            if (!sgn)
                res = {RW{1'b1}};
            else if (sum[RW])
                res = {1'b1, {(RW-1){1'b0}}};
            else
                res = {1'b0, {(RW-1){1'b1}}};
        end
        return {ovf, res};
    endfunction

    assign ws_mac  = mac(top_sum_input, activ_input, active_w, signed_mode);
    assign os_mac  = mac(acc_clear ? '0 : acc, activ_input, weight_input, signed_mode);
    assign os_pair = activ_valid_in & weight_shift_in;

    always_comb begin
        state_nxt         = state;
        shadow_w_nxt      = shadow_w;
        active_w_nxt      = active_w;
        acc_nxt           = acc;
        activ_valid_nxt   = activ_valid_out;
        activ_output_nxt  = activ_output;
        weight_shift_nxt  = weight_shift_out;
        weight_output_nxt = weight_output;
        sum_valid_nxt     = sum_valid_out;
        sum_output_nxt    = sum_output;
        overflow_nxt      = overflow;

        if (enable) begin
            activ_valid_nxt   = activ_valid_in;
            activ_output_nxt  = activ_input;
            weight_shift_nxt  = weight_shift_in;
            weight_output_nxt = weight_input;

            if (!mode) begin
                // WS always lands in RUN, which also covers the forced return on a mode change.
                state_nxt = RUN;
                if (weight_shift_in)
                    shadow_w_nxt = weight_input;
                if (weight_swap)
                    active_w_nxt = shadow_w;
                if (activ_valid_in) begin
                    sum_output_nxt = ws_mac[RW-1:0];
                    sum_valid_nxt  = 1'b1;
                    overflow_nxt   = overflow | ws_mac[RW];
                end else begin
                    sum_valid_nxt  = 1'b0;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        sum_valid_nxt = 1'b0;
                        if (drain) begin
                            sum_output_nxt = acc;
                            sum_valid_nxt  = 1'b1;
                            acc_nxt        = '0;
                            state_nxt      = DRAIN;
                        end else if (os_pair) begin
                            acc_nxt      = os_mac[RW-1:0];
                            overflow_nxt = (acc_clear ? 1'b0 : overflow) | os_mac[RW];
                        end else if (acc_clear) begin
                            acc_nxt      = '0;
                            overflow_nxt = 1'b0;
                        end
                    end
                    DRAIN: begin
                        sum_output_nxt = top_sum_input;
                        sum_valid_nxt  = top_sum_valid;
                        if (!drain)
                            state_nxt = RUN;
                    end
                    default: state_nxt = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            shadow_w         <= '0;
            active_w         <= '0;
            acc              <= '0;
            activ_valid_out  <= 1'b0;
            activ_output     <= '0;
            weight_shift_out <= 1'b0;
            weight_output    <= '0;
            sum_valid_out    <= 1'b0;
            sum_output       <= '0;
            overflow         <= 1'b0;
        end else begin
            state            <= state_nxt;
            shadow_w         <= shadow_w_nxt;
            active_w         <= active_w_nxt;
            acc              <= acc_nxt;
            activ_valid_out  <= activ_valid_nxt;
            activ_output     <= activ_output_nxt;
            weight_shift_out <= weight_shift_nxt;
            weight_output    <= weight_output_nxt;
            sum_valid_out    <= sum_valid_nxt;
            sum_output       <= sum_output_nxt;
            overflow         <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench for pe_dbuf: a saturating and a wrapping instance share all
// inputs so both overflow behaviours are checked from the same stimulus.
module tb_pe_dbuf;

    localparam int DW = 8;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          reset, enable, mode, signed_mode;
    logic          activ_valid_in, weight_shift_in, weight_swap, top_sum_valid;
    logic [DW-1:0] activ_input, weight_input;
    logic [RW-1:0] top_sum_input;
    logic          acc_clear, drain;

    logic          activ_valid_out, weight_shift_out, sum_valid_out, overflow;
    logic [DW-1:0] activ_output, weight_output;
    logic [RW-1:0] sum_output;

    logic          w_activ_valid_out, w_weight_shift_out, w_sum_valid_out, w_overflow;
    logic [DW-1:0] w_activ_output, w_weight_output;
    logic [RW-1:0] w_sum_output;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_dbuf #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .signed_mode(signed_mode),
        .activ_valid_in(activ_valid_in), .activ_input(activ_input),
        .activ_valid_out(activ_valid_out), .activ_output(activ_output),
        .weight_shift_in(weight_shift_in), .weight_input(weight_input),
        .weight_shift_out(weight_shift_out), .weight_output(weight_output),
        .weight_swap(weight_swap), .top_sum_valid(top_sum_valid), .top_sum_input(top_sum_input),
        .sum_valid_out(sum_valid_out), .sum_output(sum_output),
        .acc_clear(acc_clear), .drain(drain), .overflow(overflow)
    );

    pe_dbuf #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .signed_mode(signed_mode),
        .activ_valid_in(activ_valid_in), .activ_input(activ_input),
        .activ_valid_out(w_activ_valid_out), .activ_output(w_activ_output),
        .weight_shift_in(weight_shift_in), .weight_input(weight_input),
        .weight_shift_out(w_weight_shift_out), .weight_output(w_weight_output),
        .weight_swap(weight_swap), .top_sum_valid(top_sum_valid), .top_sum_input(top_sum_input),
        .sum_valid_out(w_sum_valid_out), .sum_output(w_sum_output),
        .acc_clear(acc_clear), .drain(drain), .overflow(w_overflow)
    );

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [RW-1:0] observed,
                               input logic [RW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit exceeded");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; mode = 1'b0; signed_mode = 1'b0;
        activ_valid_in = 1'b1; activ_input = 8'h11;
        weight_shift_in = 1'b1; weight_input = 8'h22; weight_swap = 1'b1;
        top_sum_valid = 1'b1; top_sum_input = 32'h1234;
        acc_clear = 1'b0; drain = 1'b0;
        applyStimulus(2);
        checkOutput("rst_sum", sum_output, 32'h0);
        checkOutput("rst_sum_valid", sum_valid_out, 1'b0);
        checkOutput("rst_activ", activ_output, 8'h00);
        checkOutput("rst_activ_valid", activ_valid_out, 1'b0);
        checkOutput("rst_weight", weight_output, 8'h00);
        checkOutput("rst_weight_shift", weight_shift_out, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);

        // WS signed: shift 3, swap, then (-5)*3 + 100
        reset = 1'b0; signed_mode = 1'b1;
        activ_valid_in = 1'b0; activ_input = 8'h00; weight_swap = 1'b0;
        top_sum_valid = 1'b0; top_sum_input = 32'h0;
        weight_shift_in = 1'b1; weight_input = 8'd3;
        applyStimulus(1);
        checkOutput("ws_weight_pass", weight_output, 8'd3);
        checkOutput("ws_shift_pass", weight_shift_out, 1'b1);
        weight_shift_in = 1'b0; weight_input = 8'd0; weight_swap = 1'b1;
        applyStimulus(1);
        weight_swap = 1'b0; activ_valid_in = 1'b1; activ_input = 8'hFB; top_sum_input = 32'd100;
        applyStimulus(1);
        checkOutput("ws_sum_85", sum_output, 32'd85);
        checkOutput("ws_sum_valid", sum_valid_out, 1'b1);
        checkOutput("ws_activ_pass", activ_output, 8'hFB);
        checkOutput("ws_activ_valid_pass", activ_valid_out, 1'b1);
        checkOutput("ws_wrap_sum_85", w_sum_output, 32'd85);

        // Double buffer: shift 7 with swap -> active keeps old shadow (3)
        activ_valid_in = 1'b0; weight_shift_in = 1'b1; weight_input = 8'd7; weight_swap = 1'b1;
        applyStimulus(1);
        checkOutput("ws_idle_valid", sum_valid_out, 1'b0);
        checkOutput("ws_idle_hold", sum_output, 32'd85);
        weight_shift_in = 1'b0; weight_swap = 1'b0;
        activ_valid_in = 1'b1; activ_input = 8'd2; top_sum_input = 32'd0;
        applyStimulus(1);
        checkOutput("ws_old_shadow", sum_output, 32'd6);
        activ_valid_in = 1'b0; weight_swap = 1'b1;
        applyStimulus(1);
        weight_swap = 1'b0; activ_valid_in = 1'b1;
        applyStimulus(1);
        checkOutput("ws_new_shadow", sum_output, 32'd14);

        // Signed saturation with weight 127
        activ_valid_in = 1'b0; weight_shift_in = 1'b1; weight_input = 8'h7F;
        applyStimulus(1);
        weight_shift_in = 1'b0; weight_swap = 1'b1;
        applyStimulus(1);
        weight_swap = 1'b0; activ_valid_in = 1'b1;
        activ_input = 8'h7F; top_sum_input = 32'h7FFF_FFF0;
        applyStimulus(1);
        checkOutput("sat_pos", sum_output, 32'h7FFF_FFFF);
        checkOutput("sat_pos_ovf", overflow, 1'b1);
        checkOutput("wrap_pos", w_sum_output, 32'h8000_3EF1);
        checkOutput("wrap_pos_ovf", w_overflow, 1'b1);
        activ_input = 8'h80; top_sum_input = 32'h8000_0000;
        applyStimulus(1);
        checkOutput("sat_neg", sum_output, 32'h8000_0000);
        checkOutput("wrap_neg", w_sum_output, 32'h7FFF_C080);
        activ_input = 8'd1; top_sum_input = 32'd5;
        applyStimulus(1);
        checkOutput("ovf_no_sat_sum", sum_output, 32'd132);
        checkOutput("ovf_sticky", overflow, 1'b1);

        // Unsigned saturation: 0xFFFFFF00 + 255*127
        signed_mode = 1'b0; activ_input = 8'hFF; top_sum_input = 32'hFFFF_FF00;
        applyStimulus(1);
        checkOutput("sat_uns", sum_output, 32'hFFFF_FFFF);
        checkOutput("wrap_uns", w_sum_output, 32'h0000_7D81);

        // OS unsigned: clear overflow, accumulate (2,3),(4,5),(1,1) = 27, drain
        activ_valid_in = 1'b0; top_sum_input = 32'd0; mode = 1'b1; acc_clear = 1'b1;
        applyStimulus(1);
        checkOutput("os_clear_ovf", overflow, 1'b0);
        checkOutput("os_clear_wrap_ovf", w_overflow, 1'b0);
        checkOutput("os_run_valid", sum_valid_out, 1'b0);
        acc_clear = 1'b0; activ_valid_in = 1'b1; weight_shift_in = 1'b1;
        activ_input = 8'd2; weight_input = 8'd3; applyStimulus(1);
        activ_input = 8'd4; weight_input = 8'd5; applyStimulus(1);
        activ_input = 8'd1; weight_input = 8'd1; applyStimulus(1);
        checkOutput("os_acc_valid", sum_valid_out, 1'b0);
        activ_valid_in = 1'b0; weight_shift_in = 1'b0; drain = 1'b1;
        applyStimulus(1);
        checkOutput("os_drain_27", sum_output, 32'd27);
        checkOutput("os_drain_valid", sum_valid_out, 1'b1);
        drain = 1'b0; top_sum_valid = 1'b1; top_sum_input = 32'h55;
        applyStimulus(1);
        checkOutput("os_pass_55", sum_output, 32'h55);
        checkOutput("os_pass_valid", sum_valid_out, 1'b1);
        top_sum_valid = 1'b0; top_sum_input = 32'h99;
        applyStimulus(1);
        checkOutput("os_back_run", sum_valid_out, 1'b0);
        drain = 1'b1;
        applyStimulus(1);
        checkOutput("os_acc_zero", sum_output, 32'd0);
        drain = 1'b0; top_sum_input = 32'd0;
        applyStimulus(1);

        // Simultaneous events
        activ_valid_in = 1'b1; weight_shift_in = 1'b1; activ_input = 8'd3; weight_input = 8'd3;
        applyStimulus(1);
        acc_clear = 1'b1; activ_input = 8'd6; weight_input = 8'd7;
        applyStimulus(1);
        drain = 1'b1; activ_input = 8'd1; weight_input = 8'd2;
        applyStimulus(1);
        checkOutput("clr_pair_42", sum_output, 32'd42);
        checkOutput("clr_pair_valid", sum_valid_out, 1'b1);
        acc_clear = 1'b0; drain = 1'b0; activ_valid_in = 1'b0; weight_shift_in = 1'b0;
        top_sum_input = 32'h1234;
        applyStimulus(1);
        activ_valid_in = 1'b1; weight_shift_in = 1'b1; activ_input = 8'd2; weight_input = 8'd2;
        applyStimulus(1);

        // Enable low freezes everything
        enable = 1'b0; activ_input = 8'd9; weight_input = 8'd9; drain = 1'b1;
        top_sum_valid = 1'b1; top_sum_input = 32'h999;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("frz_activ", activ_output, 8'd2);
            checkOutput("frz_activ_valid", activ_valid_out, 1'b1);
            checkOutput("frz_weight", weight_output, 8'd2);
            checkOutput("frz_sum", sum_output, 32'h1234);
            checkOutput("frz_sum_valid", sum_valid_out, 1'b0);
        end
        enable = 1'b1; activ_valid_in = 1'b0; weight_shift_in = 1'b0;
        applyStimulus(1);
        checkOutput("frz_acc_4", sum_output, 32'd4);

        // Reset while in DRAIN
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("rst_drain_sum", sum_output, 32'd0);
        checkOutput("rst_drain_valid", sum_valid_out, 1'b0);
        checkOutput("rst_drain_activ", activ_output, 8'd0);
        checkOutput("rst_drain_weight", weight_output, 8'd0);
        reset = 1'b0; drain = 1'b0; top_sum_input = 32'h77;
        applyStimulus(1);
        checkOutput("rst_state_run", sum_valid_out, 1'b0);
        activ_valid_in = 1'b1; weight_shift_in = 1'b1; activ_input = 8'd3; weight_input = 8'd4;
        top_sum_valid = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0; activ_valid_in = 1'b0; weight_shift_in = 1'b0; drain = 1'b1;
        applyStimulus(1);
        checkOutput("rst_acc_zero", sum_output, 32'd0);
        checkOutput("rst_acc_valid", sum_valid_out, 1'b1);

        // Mode change out of DRAIN forces RUN
        mode = 1'b0;
        applyStimulus(1);
        mode = 1'b1; drain = 1'b0; top_sum_valid = 1'b1; top_sum_input = 32'h66;
        applyStimulus(1);
        checkOutput("mode_chg_run", sum_valid_out, 1'b0);
        checkOutput("mode_chg_hold", sum_output, 32'd0);
        mode = 1'b0; top_sum_valid = 1'b0; activ_valid_in = 1'b1; activ_input = 8'd1;
        top_sum_input = 32'd10;
        applyStimulus(1);
        checkOutput("ws_active_rst", sum_output, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
- Next-generation systolic-array processing element with a double-buffered weight register, valid-tagged data flow, saturating arithmetic and two dataflow modes.
- Weight-stationary (WS) mode: the active weight multiplies the activation from the left and adds it to the partial sum from above.
- Output-stationary (OS) mode: the product of the left and top operands is accumulated locally, then drained down the column sum chain.
- Instantiated as a 2-D grid by the array top; neighbours connect activ_*, weight_* and sum_* ports.

Parameters:
- DATA_WIDTH, 8: operand width; RESULT_WIDTH must be >= 2*DATA_WIDTH.
- RESULT_WIDTH, 32: partial-sum and accumulator width.
- SATURATE, 1: 1 clamps on overflow; 0 wraps modulo 2^RESULT_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, every register holds its value.
- mode  in  1  0 = WS, 1 = OS.
- signed_mode  in  1  1 = operands and result are two's complement; 0 = unsigned.
- activ_valid_in  in  1  activ_input is valid.
- activ_input  in  DATA_WIDTH  activation from the left.
- activ_valid_out  out  1  registered copy of activ_valid_in.
- activ_output  out  DATA_WIDTH  registered copy of activ_input.
- weight_shift_in  in  1  weight_input is valid (WS: shadow load; OS: top operand valid).
- weight_input  in  DATA_WIDTH  weight (WS) or top operand (OS) from above.
- weight_shift_out  out  1  registered copy of weight_shift_in.
- weight_output  out  DATA_WIDTH  registered copy of weight_input.
- weight_swap  in  1  WS only: copies shadow weight into active weight.
- top_sum_valid  in  1  top_sum_input is valid (used in OS drain).
- top_sum_input  in  RESULT_WIDTH  partial sum / drain data from above.
- sum_valid_out  out  1  sum_output is valid.
- sum_output  out  RESULT_WIDTH  partial sum (WS) or drained accumulator (OS).
- acc_clear  in  1  OS only: clears the accumulator and overflow.
- drain  in  1  OS only: level signal; starts and continues the drain.
- overflow  out  1  sticky saturation/wrap flag.

Behaviour:
- Reset:
  - All outputs, shadow weight, active weight and accumulator go to 0; state = RUN.
  - Reset mid-operation discards any in-flight data.
- Enable:
  - All logic is gated by enable. With enable=0, nothing changes, including the valid outputs and the state.
- Latency and pass-through:
  - Every output is registered with 1-cycle latency.
  - activ_output/activ_valid_out and weight_output/weight_shift_out copy their inputs every enabled cycle, in both modes.
- Arithmetic:
  - prod = a*b, with both operands sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to RESULT_WIDTH.
  - sum = addend + prod, computed at RESULT_WIDTH+1 bits.
  - If the result is out of range, set overflow. With SATURATE=1, clamp to the signed max/min (signed) or to the unsigned max/0 (unsigned). With SATURATE=0, truncate.
- WS mode:
  - When weight_shift_in=1: shadow <= weight_input.
  - When weight_swap=1: active <= shadow. If shift and swap occur in the same cycle, active takes the OLD shadow.
  - When activ_valid_in=1: sum_output <= top_sum_input + activ_input*active; sum_valid_out <= 1.
  - Otherwise sum_output holds and sum_valid_out <= 0.
  - acc_clear and drain are ignored.
- OS mode, states RUN and DRAIN:
  - RUN:
    - When activ_valid_in & weight_shift_in: acc <= acc + activ_input*weight_input.
    - acc_clear in the same cycle: acc <= prod (clear first, then add); overflow cleared.
    - acc_clear alone: acc <= 0; overflow <= 0.
    - sum_valid_out <= 0.
    - drain=1 -> DRAIN, with sum_output <= acc, sum_valid_out <= 1, acc <= 0. drain has priority over accumulate and acc_clear in that cycle.
  - DRAIN:
    - sum_output <= top_sum_input; sum_valid_out <= top_sum_valid; no accumulation.
    - drain=0 -> RUN.
  - Column behaviour: a column of N PEs outputs N valid words, bottom PE first.
- Mode change:
  - A change of mode forces state = RUN on the next cycle. Weights and accumulator are retained.
  - overflow clears only on reset or acc_clear.

Test Plan:
- WS, signed, SATURATE=1:
  - Shift weight 3 into shadow, then swap.
  - Apply activ=-5, top=100 -> next cycle sum_output=85, sum_valid_out=1, activ_output=-5.
- WS double buffer:
  - Active weight=3; shift 7 with swap in the same cycle -> active=old shadow.
  - Next swap -> active=7. activ=2, top=0 -> sum_output=14.
- OS accumulate/drain, unsigned:
  - Valid pairs (2,3), (4,5), (1,1) -> acc=27.
  - drain=1 -> sum_output=27, sum_valid_out=1.
  - Next cycle passes top_sum_input=0x55 with valid=1; acc=0 after.
- Saturation, signed:
  - top=0x7FFFFFF0, activ=127, weight=127 -> sum_output=0x7FFFFFFF, overflow=1.
  - SATURATE=0 build -> wrapped value 0x80003EF1, overflow=1.
- Enable and reset:
  - enable=0 mid-accumulation -> all outputs are frozen for 3 cycles.
  - Then reset=1 while in DRAIN -> all outputs 0, state RUN, acc=0.
- Simultaneous events:
  - acc_clear with valid pair (6,7) -> acc=42.
  - drain with acc_clear and a valid pair -> sum_output=old acc, acc=0.
